// File: rtl/caches_types_pkg.sv
// Shared cache types.
//   dcnway_state_t : controller states of dcache_nway
//   HITCNT_ADDR    : word address where the hit count is stored after a flush
package caches_types_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL,
        FLUSH,
        HITCNT,
        DONE
    } dcnway_state_t;

    localparam logic [31:0] HITCNT_ADDR = 32'h0000_3100;

endpackage

// File: rtl/flex_counter.sv
// Up counter with synchronous clear.
//   CLK, nRST     : clock, asynchronous active-low reset
//   clear         : synchronous clear to zero (priority over count_enable)
//   count_enable  : increment by one this cycle
//   count_out     : current count
module flex_counter #(
    parameter int BITS = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            clear,
    input  logic            count_enable,
    output logic [BITS-1:0] count_out
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)             count_out <= '0;
        else if (clear)        count_out <= '0;
        else if (count_enable) count_out <= count_out + 1'b1;
    end

endmodule

// File: rtl/lru_ages.sv
// True-LRU age update and victim selection for one set (combinational).
//   ages       : current age of each way (0 = most recently used)
//   access_way : way being accessed
//   valid      : valid bit of each way
//   ages_next  : ages after an access to access_way
//   victim     : lowest-index invalid way, else the oldest way
module lru_ages #(
    parameter  int WAYS = 2,
    localparam int AW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0][AW-1:0] ages,
    input  logic [AW-1:0]           access_way,
    input  logic [WAYS-1:0]         valid,
    output logic [WAYS-1:0][AW-1:0] ages_next,
    output logic [AW-1:0]           victim
);

    logic [AW-1:0] old_age;
    logic          found;

    always_comb begin
        old_age = ages[access_way];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (AW'(w) == access_way)  ages_next[w] = '0;
            else if (ages[w] < old_age) ages_next[w] = ages[w] + AW'(1);
            else                        ages_next[w] = ages[w];
        end
    end

    always_comb begin
        found  = 1'b0;
        victim = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found && !valid[w]) begin
                victim = AW'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (ages[w] == AW'(WAYS - 1)) victim = AW'(w);
            end
        end
    end

endmodule

// File: rtl/dcache_nway.sv
// Parametrised write-back, write-allocate data cache with true-LRU replacement.
// On halt every dirty frame is written back, then the hit count is stored at
// HITCNT_ADDR and flushed is raised until reset.
//   CLK, nRST                 : clock, asynchronous active-low reset
//   halt                      : start flush sequence
//   dmemREN/dmemWEN/dmemaddr/dmemstore : datapath request (held until dhit)
//   dhit/dmemload             : request satisfied / read data
//   flushed                   : flush and hit-count store complete
//   dREN/dWEN/daddr/dstore    : memory request
//   dload/dwait               : memory read data / busy
module dcache_nway #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    import caches_types_pkg::*;

    localparam int WOFF = $clog2(WORDS);
    localparam int IW   = $clog2(SETS);
    localparam int TW   = 30 - WOFF - IW;
    localparam int AW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [TW-1:0]          tag;
        logic [WORDS-1:0][31:0] data;
    } frame_t;

    frame_t                  frames [SETS][WAYS];
    logic [WAYS-1:0][AW-1:0] ages   [SETS];

    dcnway_state_t state, next_state;
    logic [AW-1:0]   victim_way, victim_sel, hit_way, lru_way;
    logic [WOFF-1:0] word_cnt, woff;
    logic [IW-1:0]   flush_set, idx;
    logic [AW-1:0]   flush_way;
    logic [TW-1:0]   req_tag;
    logic [31:0]     hit_count;
    logic [WAYS-1:0] set_valid;
    logic [WAYS-1:0][AW-1:0] ages_upd;
    logic            req, hit, last_word, last_frame, fl_dirty, flush_step;
    logic [1:0]      unused_byte_off;
    frame_t          hit_frm, vic_frm, new_vic_frm, fl_frm;

    assign req_tag         = dmemaddr[31 -: TW];
    assign idx             = dmemaddr[2+WOFF +: IW];
    assign woff            = dmemaddr[2 +: WOFF];
    assign unused_byte_off = dmemaddr[1:0];
    assign req             = dmemREN | dmemWEN;
    assign last_word       = (word_cnt == WOFF'(WORDS - 1));
    assign last_frame      = (flush_set == IW'(SETS - 1)) && (flush_way == AW'(WAYS - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            set_valid[w] = frames[idx][w].valid;
            if (frames[idx][w].valid && frames[idx][w].tag == req_tag) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
        end
    end

    assign hit_frm     = frames[idx][hit_way];
    assign vic_frm     = frames[idx][victim_way];
    assign new_vic_frm = frames[idx][victim_sel];
    assign fl_frm      = frames[flush_set][flush_way];
    assign fl_dirty    = fl_frm.valid && fl_frm.dirty;
    // A flush frame is finished either after its last written-back word or,
    // when there is nothing to write, in its single visiting cycle.
    assign flush_step  = (state == FLUSH) && (!fl_dirty || (!dwait && last_word));
    assign lru_way     = (state == FILL) ? victim_way : hit_way;

    lru_ages #(.WAYS(WAYS)) u_lru (
        .ages       (ages[idx]),
        .access_way (lru_way),
        .valid      (set_valid),
        .ages_next  (ages_upd),
        .victim     (victim_sel)
    );

    flex_counter #(.BITS(32)) u_hits (
        .CLK          (CLK),
        .nRST         (nRST),
        .clear        (1'b0),
        .count_enable ((state == IDLE) && dhit && (hit_count != '1)),
        .count_out    (hit_count)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        dhit       = 1'b0;
        flushed    = 1'b0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = '0;
        dstore     = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit)                                   dhit = 1'b1;
                    else if (new_vic_frm.valid && new_vic_frm.dirty) next_state = WB;
                    else                                       next_state = FILL;
                end else if (halt) begin
                    next_state = FLUSH;
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = {vic_frm.tag, idx, word_cnt, 2'b00};
                dstore = vic_frm.data[word_cnt];
                if (!dwait && last_word) next_state = FILL;
            end
            FILL: begin
                dREN  = 1'b1;
                daddr = {req_tag, idx, word_cnt, 2'b00};
                if (!dwait && last_word) next_state = IDLE;
            end
            FLUSH: begin
                if (fl_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = {fl_frm.tag, flush_set, word_cnt, 2'b00};
                    dstore = fl_frm.data[word_cnt];
                end
                if (flush_step && last_frame) next_state = HITCNT;
            end
            HITCNT: begin
                dWEN   = 1'b1;
                daddr  = HITCNT_ADDR;
                dstore = hit_count;
                if (!dwait) next_state = DONE;
            end
            DONE:    flushed = 1'b1;
            default: next_state = IDLE;
        endcase
    end

    assign dmemload = dhit ? hit_frm.data[woff] : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            victim_way <= '0;
            word_cnt   <= '0;
            flush_set  <= '0;
            flush_way  <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    frames[s][w] <= '0;
                    ages[s][w]   <= AW'(w);
                end
            end
        end else begin
            if ((dREN || dWEN) && !dwait) word_cnt <= word_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        ages[idx] <= ages_upd;
                        if (dmemWEN) begin
                            frames[idx][hit_way].data[woff] <= dmemstore;
                            frames[idx][hit_way].dirty      <= 1'b1;
                        end
                    end else if (req) begin
                        victim_way <= victim_sel;
                        word_cnt   <= '0;
                    end else if (halt) begin
                        flush_set <= '0;
                        flush_way <= '0;
                        word_cnt  <= '0;
                    end
                end
                FILL: begin
                    if (!dwait) begin
                        frames[idx][victim_way].data[word_cnt] <= dload;
                        if (last_word) begin
                            frames[idx][victim_way].tag   <= req_tag;
                            frames[idx][victim_way].valid <= 1'b1;
                            frames[idx][victim_way].dirty <= 1'b0;
                            ages[idx]                     <= ages_upd;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_step) begin
                        frames[flush_set][flush_way].valid <= 1'b0;
                        frames[flush_set][flush_way].dirty <= 1'b0;
                        if (flush_way == AW'(WAYS - 1)) begin
                            flush_way <= '0;
                            flush_set <= flush_set + 1'b1;
                        end else begin
                            flush_way <= flush_way + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_nway.sv
module tb_dcache_nway;

    localparam int STALL = 2;
    localparam int EV_RD = 0, EV_WR = 1, EV_HR = 2, EV_HW = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        CLK, nRST, halt, dmemREN, dmemWEN, dhit, flushed;
    logic        dREN, dWEN, dwait;
    logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;

    int tests = 0;
    int fails = 0;
    ev_t sb[$];
    logic [31:0] mem [logic [31:0]];

    dcache_nway #(.SETS(8), .WAYS(2), .WORDS(2)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    // Memory: STALL busy cycles then one completing cycle per word.
    initial begin : memory_model
        int stall;
        stall = 0;
        dwait = 1'b1;
        dload = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (nRST && (dREN || dWEN)) begin
                if (stall < STALL) begin
                    dwait = 1'b1;
                    stall++;
                end else begin
                    dwait = 1'b0;
                    stall = 0;
                    if (dWEN) mem[daddr] = dstore;
                    else      dload = mem.exists(daddr) ? mem[daddr] : 32'hDEAD_BEEF;
                end
            end else begin
                dwait = 1'b1;
                stall = 0;
            end
        end
    end

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge CLK);
            if (nRST) begin
                if (dREN && dWEN) begin
                    tests++; fails++;
                    $display("FAIL both_req: dREN=1 dWEN=1 at daddr=%h", daddr);
                end
                if (dhit) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_dhit: addr=%h, no event required", dmemaddr);
                    end else begin
                        e = sb.pop_front();
                        if (!((e.kind == EV_HR && dmemREN && dmemload == e.data) ||
                              (e.kind == EV_HW && dmemWEN))) begin
                            fails++;
                            $display("FAIL hit@%h: got ren=%0b wen=%0b load=%h, required kind=%0d data=%h",
                                     dmemaddr, dmemREN, dmemWEN, dmemload, e.kind, e.data);
                        end
                    end
                end
                if ((dREN || dWEN) && !dwait) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_xfer: ren=%0b wen=%0b addr=%h data=%h",
                                 dREN, dWEN, daddr, dstore);
                    end else begin
                        e = sb.pop_front();
                        if (!((e.kind == EV_RD && dREN && daddr == e.addr) ||
                              (e.kind == EV_WR && dWEN && daddr == e.addr && dstore == e.data))) begin
                            fails++;
                            $display("FAIL xfer: got ren=%0b wen=%0b addr=%h data=%h, required kind=%0d addr=%h data=%h",
                                     dREN, dWEN, daddr, dstore, e.kind, e.addr, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit got;
        got = 0;
        @(posedge CLK); #2;
        dmemaddr = a; dmemstore = d; dmemREN = !wr; dmemWEN = wr;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge CLK);
            if (dhit) got = 1;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL req_timeout: addr=%h got no dhit, required dhit", a);
        end
        @(posedge CLK); #2;
        dmemREN = 0; dmemWEN = 0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge CLK);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset;
        nRST = 0; dmemREN = 0; dmemWEN = 0; halt = 0;
        repeat (2) @(posedge CLK);
        #2 nRST = 1;
    endtask

    initial begin
        nRST = 0; halt = 0; dmemREN = 0; dmemWEN = 0; dmemaddr = '0; dmemstore = '0;
        mem[32'h100] = 32'h0000_AAAA; mem[32'h104] = 32'h0000_BBBB;
        mem[32'h140] = 32'h0000_C140; mem[32'h144] = 32'h0000_C144;
        mem[32'h180] = 32'h0000_C180; mem[32'h184] = 32'h0000_C184;
        mem[32'h228] = 32'h0000_C228; mem[32'h22C] = 32'h0000_C22C;
        repeat (2) @(posedge CLK);
        #2;
        check("rst_dhit", 32'(dhit), 0);
        check("rst_dREN", 32'(dREN), 0);
        check("rst_dWEN", 32'(dWEN), 0);
        check("rst_flushed", 32'(flushed), 0);
        check("rst_daddr", daddr, 0);
        check("rst_dstore", dstore, 0);
        check("rst_dmemload", dmemload, 0);
        nRST = 1;

        // Cold read fill, then hit on the second word.
        push(EV_RD, 32'h100, 0); push(EV_RD, 32'h104, 0); push(EV_HR, 0, 32'h0000_AAAA);
        do_req(0, 32'h100, 0);
        push(EV_HR, 0, 32'h0000_BBBB);
        do_req(0, 32'h104, 0);
        drain("cold_read");

        // Write hit, fill way 1, then evict dirty way 0.
        push(EV_HW, 0, 0);
        do_req(1, 32'h100, 32'h1234);
        push(EV_RD, 32'h140, 0); push(EV_RD, 32'h144, 0); push(EV_HR, 0, 32'h0000_C140);
        do_req(0, 32'h140, 0);
        push(EV_WR, 32'h100, 32'h1234); push(EV_WR, 32'h104, 32'h0000_BBBB);
        push(EV_RD, 32'h180, 0); push(EV_RD, 32'h184, 0); push(EV_HR, 0, 32'h0000_C180);
        do_req(0, 32'h180, 0);
        drain("dirty_evict");

        // Clean victim: no write-back.
        do_reset();
        push(EV_RD, 32'h100, 0); push(EV_RD, 32'h104, 0); push(EV_HR, 0, 32'h1234);
        do_req(0, 32'h100, 0);
        push(EV_RD, 32'h140, 0); push(EV_RD, 32'h144, 0); push(EV_HR, 0, 32'h0000_C140);
        do_req(0, 32'h140, 0);
        push(EV_RD, 32'h180, 0); push(EV_RD, 32'h184, 0); push(EV_HR, 0, 32'h0000_C180);
        do_req(0, 32'h180, 0);
        drain("clean_evict");

        // LRU: touching 0x100 makes 0x140 the victim.
        do_reset();
        push(EV_RD, 32'h100, 0); push(EV_RD, 32'h104, 0); push(EV_HR, 0, 32'h1234);
        do_req(0, 32'h100, 0);
        push(EV_RD, 32'h140, 0); push(EV_RD, 32'h144, 0); push(EV_HR, 0, 32'h0000_C140);
        do_req(0, 32'h140, 0);
        push(EV_HR, 0, 32'h1234);
        do_req(0, 32'h100, 0);
        push(EV_RD, 32'h180, 0); push(EV_RD, 32'h184, 0); push(EV_HR, 0, 32'h0000_C180);
        do_req(0, 32'h180, 0);
        push(EV_HR, 0, 32'h1234);
        do_req(0, 32'h100, 0);
        push(EV_RD, 32'h140, 0); push(EV_RD, 32'h144, 0); push(EV_HR, 0, 32'h0000_C140);
        do_req(0, 32'h140, 0);
        drain("lru");

        // Halt: dirty sets 0 and 5, seven hits.
        do_reset();
        push(EV_RD, 32'h100, 0); push(EV_RD, 32'h104, 0); push(EV_HW, 0, 0);
        do_req(1, 32'h100, 32'h11);
        push(EV_HW, 0, 0);              do_req(1, 32'h104, 32'h22);
        push(EV_HR, 0, 32'h11);         do_req(0, 32'h100, 0);
        push(EV_RD, 32'h228, 0); push(EV_RD, 32'h22C, 0); push(EV_HW, 0, 0);
        do_req(1, 32'h228, 32'h55);
        push(EV_HR, 0, 32'h55);         do_req(0, 32'h228, 0);
        push(EV_HR, 0, 32'h0000_C22C);  do_req(0, 32'h22C, 0);
        push(EV_HR, 0, 32'h22);         do_req(0, 32'h104, 0);
        drain("pre_halt");
        push(EV_WR, 32'h100, 32'h11); push(EV_WR, 32'h104, 32'h22);
        push(EV_WR, 32'h228, 32'h55); push(EV_WR, 32'h22C, 32'h0000_C22C);
        push(EV_WR, 32'h3100, 32'd7);
        @(posedge CLK); #2 halt = 1;
        for (int n = 0; n < 300 && !flushed; n++) @(negedge CLK);
        check("flushed_set", 32'(flushed), 1);
        repeat (3) @(negedge CLK);
        check("flushed_held", 32'(flushed), 1);
        check("done_no_req", 32'({dREN, dWEN}), 0);
        drain("flush");

        // Reset during write-back drops the request and loses the dirty line.
        do_reset();
        push(EV_RD, 32'h100, 0); push(EV_RD, 32'h104, 0); push(EV_HW, 0, 0);
        do_req(1, 32'h100, 32'h77);
        push(EV_RD, 32'h140, 0); push(EV_RD, 32'h144, 0); push(EV_HR, 0, 32'h0000_C140);
        do_req(0, 32'h140, 0);
        drain("pre_wb");
        @(posedge CLK); #2;
        dmemaddr = 32'h180; dmemREN = 1;
        for (int n = 0; n < 20 && !dWEN; n++) begin
            @(posedge CLK); #2;
        end
        check("wb_started", 32'(dWEN), 1);
        nRST = 0; dmemREN = 0;
        #1;
        check("rst_mid_wb_dWEN", 32'(dWEN), 0);
        check("rst_mid_wb_daddr", daddr, 0);
        repeat (2) @(posedge CLK);
        #2 nRST = 1;
        push(EV_RD, 32'h100, 0); push(EV_RD, 32'h104, 0); push(EV_HR, 0, 32'h11);
        do_req(0, 32'h100, 0);
        drain("post_reset_miss");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
